// File: rtl/tdm_demux4_pkg.sv
// tdm_demux4 shared definitions: alignment states and slot geometry.
// Imported by tdm_align_fsm and tdm_demux4.
package tdm_demux4_pkg;

    typedef enum logic {
        TDM_HUNT = 1'b0,
        TDM_LOCK = 1'b1
    } tdm_state_e;

    localparam int NUM_SLOTS      = 4;
    localparam int SLOT_W         = 2;
    localparam int MISS_W         = 3;
    localparam int MISS_LIMIT_DEF = 2;

endpackage

// File: rtl/tdm_demux4_align_fsm.sv
// tdm_align_fsm: HUNT/LOCK frame alignment, slot counter, sync-miss counter.
// Tells the datapath which slot (if any) the current beat lands in.
module tdm_align_fsm
    import tdm_demux4_pkg::*;
#(
    parameter int MISS_LIMIT = MISS_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              fs_i,
    output logic              acc_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              locked_o,
    output logic              err_frame_o
);

    tdm_state_e        state_q;
    logic [SLOT_W-1:0] slot_q;
    logic [MISS_W-1:0] miss_q;
    logic              err_q;

    logic              at_slot0;
    logic              err_d;
    logic              lim_hit;

    assign at_slot0 = (slot_q == '0);
    assign lim_hit  = (miss_q >= MISS_W'(MISS_LIMIT - 1));
    // Sync missing on slot 0, or present anywhere else.
    assign err_d    = valid_i && (state_q == TDM_LOCK) && (at_slot0 ^ fs_i);

    always_comb begin
        acc_o  = 1'b0;
        slot_o = slot_q;
        if (valid_i) begin
            unique case (state_q)
                TDM_HUNT: begin
                    acc_o  = fs_i;
                    slot_o = '0;
                end
                TDM_LOCK: begin
                    if (err_d) begin
                        acc_o  = !lim_hit;
                        slot_o = '0;
                    end else begin
                        acc_o  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TDM_HUNT;
            slot_q  <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            if (valid_i) begin
                unique case (state_q)
                    TDM_HUNT: begin
                        if (fs_i) begin
                            state_q <= TDM_LOCK;
                            slot_q  <= SLOT_W'(1);
                            miss_q  <= '0;
                        end
                    end
                    TDM_LOCK: begin
                        if (err_d && lim_hit) begin
                            state_q <= TDM_HUNT;
                            slot_q  <= '0;
                            miss_q  <= '0;
                        end else if (err_d) begin
                            slot_q  <= SLOT_W'(1);
                            miss_q  <= miss_q + MISS_W'(1);
                        end else begin
                            slot_q  <= slot_q + SLOT_W'(1);
                            if (at_slot0) miss_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign locked_o    = (state_q == TDM_LOCK);
    assign err_frame_o = err_q;

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM demultiplexer with frame alignment.
// Optional TDM_PARITY_EN adds per-beat parity check (in_par/err_parity).
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int DW         = 8,
    parameter int MISS_LIMIT = MISS_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_fs,
`ifdef TDM_PARITY_EN
    input  logic          in_par,
    output logic          err_parity,
`endif
    output logic [DW-1:0] out_d0,
    output logic [DW-1:0] out_d1,
    output logic [DW-1:0] out_d2,
    output logic [DW-1:0] out_d3,
    output logic          out_valid,
    output logic          locked,
    output logic          err_frame
);

    logic              acc;
    logic [SLOT_W-1:0] slot;
    logic              bad_now;

    logic [DW-1:0] cap0_q, cap1_q, cap2_q;
    logic [DW-1:0] d0_q, d1_q, d2_q, d3_q;
    logic          valid_q;

    tdm_align_fsm #(
        .MISS_LIMIT (MISS_LIMIT)
    ) u_align (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (in_valid),
        .fs_i        (in_fs),
        .acc_o       (acc),
        .slot_o      (slot),
        .locked_o    (locked),
        .err_frame_o (err_frame)
    );

`ifdef TDM_PARITY_EN
    logic par_err;
    logic bad_q;
    logic perr_q;

    assign par_err = in_valid && (in_par != ^in_data);
    // A slot-0 beat starts a fresh frame, so history is dropped there.
    assign bad_now = par_err || (bad_q && (slot != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            perr_q <= par_err;
            if (acc) bad_q <= bad_now;
        end
    end

    assign err_parity = perr_q;
`else
    assign bad_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap0_q  <= '0;
            cap1_q  <= '0;
            cap2_q  <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (acc) begin
                unique case (slot)
                    2'd0: cap0_q <= in_data;
                    2'd1: cap1_q <= in_data;
                    2'd2: cap2_q <= in_data;
                    2'd3: begin
                        if (!bad_now) begin
                            d0_q    <= cap0_q;
                            d1_q    <= cap1_q;
                            d2_q    <= cap2_q;
                            d3_q    <= in_data;
                            valid_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign out_d0    = d0_q;
    assign out_d1    = d1_q;
    assign out_d2    = d2_q;
    assign out_d3    = d3_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: randomized stimulus against a frame-level queue model.
// Define TDM_PARITY_EN to also exercise the parity path.
module tb_tdm_demux4;

    localparam int DW  = 8;
    localparam int LIM = 2;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         fs;
        bit         pok;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_fs = 1'b0;
    logic [DW-1:0] out_d0, out_d1, out_d2, out_d3;
    logic          out_valid, locked, err_frame;
`ifdef TDM_PARITY_EN
    logic          in_par = 1'b0;
    logic          err_parity;
`else
    logic          err_parity;
    assign err_parity = 1'b0;
`endif

    tdm_demux4 #(.DW(DW), .MISS_LIMIT(LIM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_fs      (in_fs),
`ifdef TDM_PARITY_EN
        .in_par     (in_par),
        .err_parity (err_parity),
`endif
        .out_d0     (out_d0),
        .out_d1     (out_d1),
        .out_d2     (out_d2),
        .out_d3     (out_d3),
        .out_valid  (out_valid),
        .locked     (locked),
        .err_frame  (err_frame)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Frame-level reference: a queue of the beats gathered so far.
    bit         m_lock;
    logic [7:0] m_frame[$];
    int         m_miss;
    logic [7:0] m_out[4];
    bit         m_bad;
    bit         e_valid, e_err, e_perr;
    beat_t      bq[$];

    function automatic logic [35:0] obs();
        return {out_valid, err_frame, locked, err_parity,
                out_d3, out_d2, out_d1, out_d0};
    endfunction

    function automatic logic [35:0] expv();
        return {e_valid, e_err, m_lock, e_perr,
                m_out[3], m_out[2], m_out[1], m_out[0]};
    endfunction

    task automatic model_reset();
        m_lock = 0;
        m_frame = {};
        m_miss = 0;
        m_bad = 0;
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        e_valid = 0;
        e_err = 0;
        e_perr = 0;
    endtask

    task automatic model_beat(input logic [7:0] d, input bit fs, input bit pok);
        e_valid = 0;
        e_err = 0;
`ifdef TDM_PARITY_EN
        e_perr = !pok;
`else
        e_perr = 0;
`endif
        if (!m_lock) begin
            if (fs) begin
                m_lock = 1;
                m_frame = {d};
                m_miss = 0;
                m_bad = !pok;
            end
        end else if (m_frame.size() == 0 && fs) begin
            m_frame = {d};
            m_miss = 0;
            m_bad = !pok;
        end else if (m_frame.size() == 0 || fs) begin
            e_err = 1;
            m_miss++;
            if (m_miss >= LIM) begin
                m_lock = 0;
                m_frame = {};
                m_miss = 0;
            end else begin
                m_frame = {d};
                m_bad = !pok;
            end
        end else begin
            m_frame.push_back(d);
            m_bad = m_bad | !pok;
            if (m_frame.size() == 4) begin
                if (!m_bad) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                    e_valid = 1;
                end
                m_frame = {};
            end
        end
    endtask

    task automatic step(input beat_t b);
        in_valid = b.v;
        in_data  = b.d;
        in_fs    = b.fs;
`ifdef TDM_PARITY_EN
        in_par   = (^b.d) ^ !b.pok;
`endif
        if (b.v) model_beat(b.d, b.fs, b.pok);
        else begin
            e_valid = 0;
            e_err = 0;
            e_perr = 0;
        end
        @(negedge clk);
    endtask

    task automatic push_beat(input logic [7:0] d, input bit fs,
                             input bit pok, input int maxgap);
        beat_t b;
        int gap = $urandom_range(maxgap, 0);
        for (int i = 0; i < gap; i++) begin
            b.v = 0;
            b.d = 8'($urandom);
            b.fs = 1'($urandom);
            b.pok = 1;
            bq.push_back(b);
        end
        b.v = 1;
        b.d = d;
        b.fs = fs;
        b.pok = pok;
        bq.push_back(b);
    endtask

    task automatic push_frame(input bit fs, input int maxgap);
        for (int s = 0; s < 4; s++)
            push_beat(8'($urandom), fs && s == 0, 1, maxgap);
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== expv())
            $display("FAIL reset: got %h want %h", obs(), expv());
        else passed++;
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_aligned();
        bq = {};
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < 4; s++)
                push_beat(8'(8'h10 + 4 * k + s), s == 0, 1, 0);
        foreach (bq[i]) begin
            step(bq[i]);
            checks++;
            if (obs() !== expv())
                $display("FAIL aligned[%0d]: got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_gaps();
        bq = {};
        repeat (4) push_frame(1, 3);
        foreach (bq[i]) begin
            step(bq[i]);
            checks++;
            if (obs() !== expv())
                $display("FAIL gaps[%0d]: got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_early_fs();
        bq = {};
        push_frame(1, 1);
        push_beat(8'hA0, 1, 1, 1);
        push_beat(8'hA1, 0, 1, 1);
        push_frame(1, 1);
        push_frame(1, 0);
        foreach (bq[i]) begin
            step(bq[i]);
            checks++;
            if (obs() !== expv())
                $display("FAIL early_fs[%0d]: got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_missing_fs();
        bq = {};
        push_frame(1, 0);
        push_frame(0, 1);
        push_frame(0, 1);
        push_frame(1, 1);
        push_frame(1, 0);
        foreach (bq[i]) begin
            step(bq[i]);
            checks++;
            if (obs() !== expv())
                $display("FAIL missing_fs[%0d]: got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_reset_midframe();
        bq = {};
        push_frame(1, 0);
        push_beat(8'h55, 1, 1, 0);
        push_beat(8'h66, 0, 1, 0);
        foreach (bq[i]) step(bq[i]);
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs() !== expv())
            $display("FAIL async_reset: got %h want %h", obs(), expv());
        else passed++;
        @(negedge clk);
        rst_n = 1;
        bq = {};
        push_frame(0, 1);
        push_frame(1, 1);
        push_frame(1, 0);
        foreach (bq[i]) begin
            step(bq[i]);
            checks++;
            if (obs() !== expv())
                $display("FAIL post_reset[%0d]: got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_random();
        beat_t b;
        for (int i = 0; i < 300; i++) begin
            b.v = ($urandom_range(3, 0) != 0);
            b.d = 8'($urandom);
            b.fs = ($urandom_range(4, 0) == 0);
`ifdef TDM_PARITY_EN
            b.pok = ($urandom_range(9, 0) != 0);
`else
            b.pok = 1;
`endif
            step(b);
            checks++;
            if (obs() !== expv())
                $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask

`ifdef TDM_PARITY_EN
    task automatic test_parity();
        bq = {};
        push_frame(1, 0);
        push_beat(8'h01, 1, 1, 0);
        push_beat(8'h03, 0, 0, 0);
        push_beat(8'h05, 0, 1, 0);
        push_beat(8'h07, 0, 1, 0);
        push_frame(1, 1);
        foreach (bq[i]) begin
            step(bq[i]);
            checks++;
            if (obs() !== expv())
                $display("FAIL parity[%0d]: got %h want %h", i, obs(), expv());
            else passed++;
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_aligned();
        test_gaps();
        test_early_fs();
        test_missing_fs();
        test_reset_midframe();
`ifdef TDM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
